// File: rtl/rtl_logic_gates.sv
// rtl_logic_gates: registered bitwise NOT/NOR/OR/AND/NAND/XOR/XNOR evaluator with valid tag
module rtl_logic_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] not_g,
  output logic [WIDTH-1:0] nor_g,
  output logic [WIDTH-1:0] or_g,
  output logic [WIDTH-1:0] and_g,
  output logic [WIDTH-1:0] nand_g,
  output logic [WIDTH-1:0] xor_g,
  output logic [WIDTH-1:0] xnor_g,
  output logic             out_valid
);
  logic [WIDTH-1:0] r_not, r_nor, r_or, r_and, r_nand, r_xor, r_xnor;
  logic             r_valid;
  // Capture all gates together on accepted operands; reset clears everything, even active-low-style gates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_not   <= '0;
      r_nor   <= '0;
      r_or    <= '0;
      r_and   <= '0;
      r_nand  <= '0;
      r_xor   <= '0;
      r_xnor  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_not  <= ~a;
        r_nor  <= ~(a | b);
        r_or   <= a | b;
        r_and  <= a & b;
        r_nand <= ~(a & b);
        r_xor  <= a ^ b;
        r_xnor <= ~(a ^ b);
      end
    end
  end
  assign not_g     = r_not;
  assign nor_g     = r_nor;
  assign or_g      = r_or;
  assign and_g     = r_and;
  assign nand_g    = r_nand;
  assign xor_g     = r_xor;
  assign xnor_g    = r_xnor;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_rtl_logic_gates.sv
// tb_rtl_logic_gates: directed + random checks of rtl_logic_gates at WIDTH=1 and WIDTH=4
module tb_rtl_logic_gates;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] not4, nor4, or4, and4, nand4, xor4, xnor4;
  logic       v4;
  logic       not1, nor1, or1, and1, nand1, xor1, xnor1;
  logic       v1;
  logic [27:0] e_g = '0;
  logic        e_v = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtl_logic_gates #(.WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .not_g(not4), .nor_g(nor4), .or_g(or4), .and_g(and4),
    .nand_g(nand4), .xor_g(xor4), .xnor_g(xnor4), .out_valid(v4)
  );

  rtl_logic_gates #(.WIDTH(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4[0]), .b(b4[0]),
    .not_g(not1), .nor_g(nor1), .or_g(or1), .and_g(and1),
    .nand_g(nand1), .xor_g(xor1), .xnor_g(xnor1), .out_valid(v1)
  );

  // Truth-table model: count of ones per lane decides each gate.
  function automatic logic [27:0] model(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] n, no, o, an, na, xo, xn;
    for (int i = 0; i < 4; i++) begin
      int s;
      s     = int'(x[i]) + int'(y[i]);
      n[i]  = (x[i] == 1'b0);
      o[i]  = (s > 0);
      an[i] = (s == 2);
      xo[i] = (s == 1);
      no[i] = (s == 0);
      na[i] = (s != 2);
      xn[i] = (s != 1);
    end
    return {n, no, o, an, na, xo, xn};
  endfunction

  function automatic logic [6:0] lane0(input logic [27:0] g);
    logic [6:0] r;
    for (int k = 0; k < 7; k++) r[k] = g[4*k];
    return r;
  endfunction

  task automatic check(input string tag);
    logic [27:0] o4;
    logic [6:0]  o1;
    o4 = {not4, nor4, or4, and4, nand4, xor4, xnor4};
    o1 = {not1, nor1, or1, and1, nand1, xor1, xnor1};
    checks++;
    assert (o4 === e_g) else begin errors++; $error("FAIL %s w4_gates observed=%h expected=%h", tag, o4, e_g); end
    checks++;
    assert (v4 === e_v) else begin errors++; $error("FAIL %s w4_valid observed=%b expected=%b", tag, v4, e_v); end
    checks++;
    assert (o1 === lane0(e_g)) else begin errors++; $error("FAIL %s w1_gates observed=%b expected=%b", tag, o1, lane0(e_g)); end
    checks++;
    assert (v1 === e_v) else begin errors++; $error("FAIL %s w1_valid observed=%b expected=%b", tag, v1, e_v); end
    if (v4) begin
      checks++;
      assert ({nor4, nand4, xnor4} === ~{or4, and4, xor4}) else begin
        errors++; $error("FAIL %s invariant observed=%h expected=%h", tag, {nor4, nand4, xnor4}, ~{or4, and4, xor4});
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic v, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    rst = r; in_valid = v; a4 = x; b4 = y;
    @(posedge clk);
    if (r) begin
      e_g = '0; e_v = 1'b0;
    end else begin
      e_v = v;
      if (v) e_g = model(x, y);
    end
    #1 check(tag);
  endtask

  initial begin
    step("reset0", 1'b1, 1'b0, 4'bxxxx, 4'bxxxx);
    step("reset1", 1'b1, 1'b1, 4'bxxxx, 4'bxxxx);
    step("idle_x", 1'b0, 1'b0, 4'bxxxx, 4'bxxxx);
    step("idle0", 1'b0, 1'b0, 4'b0000, 4'b0000);
    step("ab00", 1'b0, 1'b1, 4'b0000, 4'b0000);
    step("ab01", 1'b0, 1'b1, 4'b0000, 4'b0001);
    step("ab10", 1'b0, 1'b1, 4'b0001, 4'b0000);
    step("ab11", 1'b0, 1'b1, 4'b0001, 4'b0001);
    step("hold", 1'b0, 1'b0, 4'b0000, 4'b0000);
    step("hold2", 1'b0, 1'b0, 4'b1111, 4'b0101);
    step("rst_iv", 1'b1, 1'b1, 4'b1111, 4'b1111);
    step("w4", 1'b0, 1'b1, 4'b1100, 4'b1010);
    step("w4_hold", 1'b0, 1'b0, 4'b0011, 4'b0110);
    for (int i = 0; i < 300; i++) begin
      logic [3:0] x, y;
      x = 4'($urandom);
      y = 4'($urandom);
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), x, y);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
